// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-forward select encodings, register
// address width and the per-stage hazard tracking slot.
package pipe_pkg;

  localparam int unsigned REG_AW = 5;

  // EX operand mux select encodings
  localparam logic [1:0] FWD_REG  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB   = 2'b01;  // MEM/WB write-back data
  localparam logic [1:0] FWD_MEM  = 2'b10;  // EX/MEM ALU result
  localparam logic [1:0] FWD_RSVD = 2'b11;  // never driven

  // Destination status of one in-flight instruction
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

endpackage

// File: rtl/fwd_sel_calc.sv
// Combinational forward-select computation for one EX source operand.
// Ports:
//   use_src        - instruction in ID reads this source
//   rs             - source register address
//   idex_rd/_rw    - destination of the instruction currently in ID/EX
//   exmem_rd/_rw   - destination of the instruction currently in EX/MEM
//   sel_c          - select to be registered into EX next edge
module fwd_sel_calc
  import pipe_pkg::*;
#(
  parameter int unsigned AW = REG_AW
) (
  input  logic          use_src,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] idex_rd,
  input  logic          idex_rw,
  input  logic [AW-1:0] exmem_rd,
  input  logic          exmem_rw,
  output logic [1:0]    sel_c
);

  logic live_c;

  // x0 is hardwired zero, so it never needs a forward
  assign live_c = use_src && (rs != '0);

  // The ID/EX producer will sit in EX/MEM when the consumer reaches EX, and
  // the EX/MEM producer will sit in MEM/WB; the younger one wins.
  always_comb begin
    sel_c = FWD_REG;
    if (live_c && idex_rw && (rs == idex_rd)) begin
      sel_c = FWD_MEM;
    end else if (live_c && exmem_rw && (rs == exmem_rd)) begin
      sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_forward_ctrl.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks the ID/EX, EX/MEM and MEM/WB destinations, precomputes the EX
// operand-mux selects in ID and registers them into EX, and raises a
// combinational stall when ID consumes the result of a load sitting in EX.
// Ports:
//   clk_i, rst_n_i            - clock, async active-low reset
//   id_*                      - decoded instruction currently in ID
//   hold_i                    - global freeze (memory wait)
//   flush_i                   - kill the instruction entering EX
//   fwd_a_sel_o, fwd_b_sel_o  - registered EX src A/B mux selects
//   stall_o                   - combinational load-use stall
//   stall_cnt_o               - saturating stall-cycle counter
module ex_forward_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = pipe_pkg::REG_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  slot_t      idex;
  slot_t      exmem;
  slot_t      memwb;
  logic [1:0] sel_a_c;
  logic [1:0] sel_b_c;
  logic       kill_c;
  logic       id_live_c;
  logic       unused_ok;

  fwd_sel_calc #(.AW(REG_AW)) u_sel_a (
    .use_src  (id_use_rs1_i),
    .rs       (id_rs1_i),
    .idex_rd  (idex.rd),
    .idex_rw  (idex.regwrite),
    .exmem_rd (exmem.rd),
    .exmem_rw (exmem.regwrite),
    .sel_c    (sel_a_c)
  );

  fwd_sel_calc #(.AW(REG_AW)) u_sel_b (
    .use_src  (id_use_rs2_i),
    .rs       (id_rs2_i),
    .idex_rd  (idex.rd),
    .idex_rw  (idex.regwrite),
    .exmem_rd (exmem.rd),
    .exmem_rw (exmem.regwrite),
    .sel_c    (sel_b_c)
  );

  // Load result is not available until MEM, so a dependent in ID must wait
  always_comb begin
    stall_o = 1'b0;
    if (id_valid_i && idex.memread && (idex.rd != '0)) begin
      stall_o = (id_use_rs1_i && (id_rs1_i == idex.rd)) ||
                (id_use_rs2_i && (id_rs2_i == idex.rd));
    end
  end

  assign kill_c    = stall_o || flush_i;
  assign id_live_c = id_valid_i && !kill_c;

  // Slot pipeline, select registers and stall counter; all frozen by hold_i
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idex        <= SLOT_EMPTY;
      exmem       <= SLOT_EMPTY;
      memwb       <= SLOT_EMPTY;
      fwd_a_sel_o <= FWD_REG;
      fwd_b_sel_o <= FWD_REG;
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      memwb <= exmem;
      exmem <= idex;
      if (id_live_c) begin
        idex.rd       <= id_rd_i;
        idex.regwrite <= id_regwrite_i;
        idex.memread  <= id_memread_i;
      end else begin
        idex <= SLOT_EMPTY;
      end
      fwd_a_sel_o <= kill_c ? FWD_REG : sel_a_c;
      fwd_b_sel_o <= kill_c ? FWD_REG : sel_b_c;
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
    end
  end

  // The reserved encoding must never reach the operand muxes
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      assert (fwd_a_sel_o != FWD_RSVD && fwd_b_sel_o != FWD_RSVD);
    end
  end

  // MEM/WB is tracked for completeness; the register file covers it
  assign unused_ok = ^{memwb, exmem.memread};

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Scoreboard bench for ex_forward_ctrl (narrow counter to reach saturation).
module tb_ex_forward_ctrl;
  import pipe_pkg::*;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic          hold, flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall;
  logic [CW-1:0] stall_cnt;

  typedef struct packed {
    logic [1:0]    a;
    logic [1:0]    b;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic [CW-1:0] cnt;

  ex_forward_ctrl #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .id_valid_i    (id_valid),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .hold_i        (hold),
    .flush_i       (flush),
    .fwd_a_sel_o   (fwd_a_sel),
    .fwd_b_sel_o   (fwd_b_sel),
    .stall_o       (stall),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One ID cycle: drive, check the combinational stall, queue the EX-cycle
  // expectation, then compare it after the edge.
  task automatic step(input string tag, input logic v,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic mr,
                      input logic hd, input logic fl, input logic es,
                      input logic [1:0] ea, input logic [1:0] eb,
                      input logic [CW-1:0] ec);
    exp_t e;
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; hold = hd; flush = fl;
    #1;
    check({tag, ".stall"}, 32'(stall), 32'(es));
    e.a = ea; e.b = eb; e.cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".sel_a"}, 32'(fwd_a_sel), 32'(e.a));
    check({tag, ".sel_b"}, 32'(fwd_b_sel), 32'(e.b));
    check({tag, ".cnt"},   32'(stall_cnt), 32'(e.cnt));
  endtask

  task automatic nop(input logic [CW-1:0] ec);
    step("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ec);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0;
    id_use_rs2 = 0; id_rd = 0; id_regwrite = 0; id_memread = 0;
    hold = 0; flush = 0; cnt = '0;
    #1;
    check("rst.sel_a", 32'(fwd_a_sel), 0);
    check("rst.sel_b", 32'(fwd_b_sel), 0);
    check("rst.stall", 32'(stall), 0);
    check("rst.cnt",   32'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // EX->EX: add x5 then sub reads x5 on rs1
    step("ex_add",  1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("ex_sub",  1, 5, 6, 1, 1, 8, 1, 0, 0, 0, 0, 2'b10, 2'b00, cnt);
    nop(cnt); nop(cnt);

    // Two producers of x7: youngest wins
    step("pri_n",   1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("pri_n1",  1, 3, 4, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("pri_n2",  1, 9, 7, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, cnt);
    nop(cnt); nop(cnt);
    // Only the older one writes x7
    step("wb_n",    1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("wb_n1",   1, 3, 4, 1, 1, 10, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("wb_n2",   1, 9, 7, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, cnt);
    nop(cnt); nop(cnt);

    // Load-use: one bubble, then forward from write-back
    step("lu_lw",   1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 2'b00, 2'b00, cnt);
    cnt = cnt + 1'b1;
    step("lu_stl",  1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, cnt);
    step("lu_add",  1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0, 2'b01, 2'b00, cnt);
    nop(cnt); nop(cnt);

    // x0 never stalls or forwards; unused rs2 never forwards
    step("x0_lw",   1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("x0_rd",   1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("nu_prod", 1, 1, 0, 1, 0, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("nu_cons", 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    nop(cnt); nop(cnt);

    // Hold during a stall freezes everything; flush under hold is ignored
    step("hd_lw",   1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("hd_h1",   1, 3, 4, 1, 1, 6, 1, 0, 1, 0, 1, 2'b00, 2'b00, cnt);
    step("hd_h2",   1, 3, 4, 1, 1, 6, 1, 0, 1, 0, 1, 2'b00, 2'b00, cnt);
    step("hd_h3f",  1, 3, 4, 1, 1, 6, 1, 0, 1, 1, 1, 2'b00, 2'b00, cnt);
    cnt = cnt + 1'b1;
    step("hd_stl",  1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, cnt);
    step("hd_add",  1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0, 2'b01, 2'b00, cnt);
    nop(cnt); nop(cnt);

    // Flush held off by hold, then taking effect once hold drops
    step("fl_p1",   1, 1, 0, 1, 0, 11, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("fl_p2",   1, 11, 0, 1, 0, 12, 1, 0, 0, 0, 0, 2'b10, 2'b00, cnt);
    step("fl_hold", 1, 12, 0, 1, 0, 14, 1, 0, 1, 1, 0, 2'b10, 2'b00, cnt);
    step("fl_kill", 1, 12, 0, 1, 0, 14, 1, 0, 0, 1, 0, 2'b00, 2'b00, cnt);
    step("fl_p4",   1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, cnt);
    nop(cnt); nop(cnt);

    // Drive the narrow counter into saturation
    for (int i = 0; i < 14; i++) begin
      step("sat_lw",  1, 1, 0, 1, 0, 3, 1, 1, 0, 0, 0, 2'b00, 2'b00, cnt);
      if (cnt != '1) cnt = cnt + 1'b1;
      step("sat_stl", 1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, cnt);
      step("sat_add", 1, 3, 4, 1, 1, 6, 1, 0, 0, 0, 0, 2'b01, 2'b00, cnt);
    end
    check("sat.max", 32'(stall_cnt), 15);

    // Reset in the middle of a stall acts without a clock edge
    step("rs_prod", 1, 1, 0, 1, 0, 13, 1, 0, 0, 0, 0, 2'b00, 2'b00, cnt);
    step("rs_lw",   1, 13, 0, 1, 0, 3, 1, 1, 0, 0, 0, 2'b10, 2'b00, cnt);
    @(negedge clk);
    id_valid = 1; id_rs1 = 3; id_rs2 = 4; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 6; id_regwrite = 1; id_memread = 0; hold = 0; flush = 0;
    #1;
    check("rs.pre_stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    check("rs.stall", 32'(stall), 0);
    check("rs.sel_a", 32'(fwd_a_sel), 0);
    check("rs.sel_b", 32'(fwd_b_sel), 0);
    check("rs.cnt",   32'(stall_cnt), 0);
    check("rs.sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
